// File: rtl/mem_bus_arbiter.sv
// Two-port data-bus controller. Port C (CPU M-stage) and port D (DMA/loader)
// share one data memory and two timers. Grants are round-robin. Each access is
// checked for legality, then the slave strobe is sequenced. The owner sees a
// one-cycle ack that carries either read data or an error flag.
module mem_bus_arbiter #(
  parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
  parameter logic [31:0] T0_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,

  // Port C
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic        c_err,
  output logic [31:0] c_rdata,

  // Port D
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,

  // Data memory
  output logic        dm_en,
  output logic [3:0]  dm_we,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,

  // Timers
  output logic [1:0]  tm_we,
  output logic [1:0]  tm_addr,
  output logic [31:0] tm_wdata,
  input  logic [31:0] tm0_rdata,
  input  logic [31:0] tm1_rdata,

  output logic        owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [1:0] {TgtDm, TgtT0, TgtT1} tgt_e;

  // Each timer has three word registers (12 bytes).
  localparam logic [31:0] TimerSpan = 32'h0000_000B;

  state_e      state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [13:2] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Request selection and legality decode
  logic        any_req;
  logic        grant_d;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        in_dm, in_t0, in_t1;
  logic        be_ok, timer_ok, legal;
  tgt_e        sel_tgt;

  // Round-robin pick: D wins only if C is idle or C was served last.
  always_comb begin
    any_req   = c_req | d_req;
    grant_d   = d_req & (~c_req | ~last_owner_q);
    sel_we    = grant_d ? d_we    : c_we;
    sel_addr  = grant_d ? d_addr  : c_addr;
    sel_be    = grant_d ? d_be    : c_be;
    sel_wdata = grant_d ? d_wdata : c_wdata;
  end

  // Decode the selected request's target and legality.
  always_comb begin
    in_dm = (sel_addr <= DM_TOP);
    in_t0 = (sel_addr >= T0_BASE) && (sel_addr <= T0_BASE + TimerSpan);
    in_t1 = (sel_addr >= T1_BASE) && (sel_addr <= T1_BASE + TimerSpan);

    case (sel_be)
      4'b1111: be_ok = (sel_addr[1:0] == 2'b00);
      4'b0011: be_ok = (sel_addr[1:0] == 2'b00);
      4'b1100: be_ok = (sel_addr[1:0] == 2'b10);
      default: be_ok = (sel_be == (4'b0001 << sel_addr[1:0]));
    endcase

    // Timers take whole words only, and COUNT (word 2) is read-only.
    timer_ok = (sel_be == 4'b1111) && !(sel_we && (sel_addr[3:2] == 2'b10));

    legal = be_ok && (in_dm || ((in_t0 || in_t1) && timer_ok));

    if (in_t0) begin
      sel_tgt = TgtT0;
    end else if (in_t1) begin
      sel_tgt = TgtT1;
    end else begin
      sel_tgt = TgtDm;
    end
  end

  // Next-state logic for the transaction FSM and latched request.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d      = grant_d;
          last_owner_d = grant_d;
          we_d         = sel_we;
          addr_d       = sel_addr[13:2];
          be_d         = sel_be;
          wdata_d      = sel_wdata;
          tgt_d        = sel_tgt;
          err_d        = ~legal;
          rdata_d      = '0;
          state_d      = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        // Timer reads are combinational; hold the value for the response cycle.
        if (!we_q && (tgt_q == TgtT0)) begin
          rdata_d = tm0_rdata;
        end else if (!we_q && (tgt_q == TgtT1)) begin
          rdata_d = tm1_rdata;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; async reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      tgt_q        <= TgtDm;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  logic [31:0] resp_rdata;

  // Slave strobes in ACCESS only; ack and response data in RESP only.
  always_comb begin
    dm_en      = 1'b0;
    dm_we      = 4'b0000;
    dm_addr    = '0;
    dm_wdata   = '0;
    tm_we      = 2'b00;
    tm_addr    = 2'b00;
    tm_wdata   = '0;
    c_ack      = 1'b0;
    c_err      = 1'b0;
    c_rdata    = '0;
    d_ack      = 1'b0;
    d_err      = 1'b0;
    d_rdata    = '0;
    resp_rdata = '0;

    // An errored request jumps straight to RESP, so no strobe can fire for it.
    if (state_q == StAccess) begin
      case (tgt_q)
        TgtDm: begin
          dm_en    = 1'b1;
          dm_we    = we_q ? be_q : 4'b0000;
          dm_addr  = addr_q;
          dm_wdata = wdata_q;
        end
        TgtT0: begin
          tm_we    = {1'b0, we_q};
          tm_addr  = addr_q[3:2];
          tm_wdata = wdata_q;
        end
        TgtT1: begin
          tm_we    = {we_q, 1'b0};
          tm_addr  = addr_q[3:2];
          tm_wdata = wdata_q;
        end
        default: begin
          dm_en = 1'b0;
        end
      endcase
    end

    if (state_q == StResp) begin
      if (!err_q && !we_q) begin
        resp_rdata = (tgt_q == TgtDm) ? dm_rdata : rdata_q;
      end
      if (owner_q) begin
        d_ack   = 1'b1;
        d_err   = err_q;
        d_rdata = resp_rdata;
      end else begin
        c_ack   = 1'b1;
        c_err   = err_q;
        c_rdata = resp_rdata;
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small DM and timer slave model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_be, d_be;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        dm_en;
  logic [3:0]  dm_we;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [1:0]  tm_we, tm_addr;
  logic [31:0] tm_wdata, tm0_rdata, tm1_rdata;
  logic        owner;

  mem_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_be      (c_be),
    .c_wdata   (c_wdata),
    .c_ack     (c_ack),
    .c_err     (c_err),
    .c_rdata   (c_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_be      (d_be),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .dm_en     (dm_en),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .tm_we     (tm_we),
    .tm_addr   (tm_addr),
    .tm_wdata  (tm_wdata),
    .tm0_rdata (tm0_rdata),
    .tm1_rdata (tm1_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory model.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (dm_en) begin
      dm_rdata <= mem[dm_addr];
      for (int b = 0; b < 4; b++) begin
        if (dm_we[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  // Timer 1 returns 5 only while PRESET is addressed, so the response must use
  // the value captured during ACCESS.
  assign tm0_rdata = 32'h0000_AAAA;
  assign tm1_rdata = (tm_addr == 2'b01) ? 32'h0000_0005 : 32'hFFFF_0000;

  int checks = 0;
  int errors = 0;

  logic [3:0] acc_dm_we;
  logic [1:0] acc_tm_we, acc_tm_addr;
  logic       strobe_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (dm_en) begin
      strobe_seen = 1'b1;
      acc_dm_we   = acc_dm_we | dm_we;
    end
    if (tm_we != 2'b00) strobe_seen = 1'b1;
    acc_tm_we   = acc_tm_we | tm_we;
    acc_tm_addr = acc_tm_addr | tm_addr;
  endtask

  // One port C transaction; lat counts cycles from the sampling edge to ack.
  task automatic c_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic err);
    c_req = 1'b1; c_we = we; c_addr = addr; c_be = be; c_wdata = wdata;
    acc_dm_we = '0; acc_tm_we = '0; acc_tm_addr = '0; strobe_seen = 1'b0;
    lat = -1; rd = 'x; err = 1'bx;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(posedge clk); #1;
      monitor();
      if (c_ack) begin
        lat = i; rd = c_rdata; err = c_err;
        c_req = 1'b0;
      end
    end
    c_req = 1'b0;
    @(posedge clk); #1;
    monitor();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          acks;
  logic        who;

  logic [31:0] bad_addr [4];
  logic [3:0]  bad_be   [4];
  logic        bad_we   [4];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_be = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_be = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {26'd0, c_ack, c_err, d_ack, d_err, dm_en, owner}, 32'd0);
    check("reset_strobes", {22'd0, dm_we, tm_we, tm_addr, 2'b00}, 32'd0);
    check("reset_data", c_rdata | d_rdata | dm_wdata | tm_wdata | {20'd0, dm_addr}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Arbitration: both held high, grants alternate starting with C.
    c_we = 0; c_addr = 32'h10; c_be = 4'hF;
    d_we = 0; d_addr = 32'h14; d_be = 4'hF;
    c_req = 1'b1; d_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(posedge clk); #1;
      if (c_ack || d_ack) begin
        who = d_ack;
        check("arb_single_ack", {31'd0, c_ack & d_ack}, 32'd0);
        check("arb_owner", {31'd0, owner}, {31'd0, who});
        check($sformatf("arb_grant%0d", acks), {31'd0, who}, {31'd0, acks[0]});
        acks++;
        if (acks == 4) begin
          c_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    check("arb_ack_count", acks, 32'd4);
    @(posedge clk); #1;

    // DM word write then read back.
    c_txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, rd, err);
    check("dm_wr_lat", lat, 32'd2);
    check("dm_wr_err", {31'd0, err}, 32'd0);
    check("dm_wr_we", {28'd0, acc_dm_we}, 32'hF);
    check("dm_wr_rdata", rd, 32'd0);
    c_txn(1'b0, 32'h10, 4'hF, 32'h0, lat, rd, err);
    check("dm_rd_lat", lat, 32'd2);
    check("dm_rd_data", rd, 32'hDEAD_BEEF);
    check("dm_rd_we", {27'd0, strobe_seen, acc_dm_we}, 32'h10);

    // Single-byte write into lane 1.
    c_txn(1'b1, 32'h11, 4'b0010, 32'h0000_5A00, lat, rd, err);
    check("byte_wr_err", {31'd0, err}, 32'd0);
    check("byte_wr_we", {28'd0, acc_dm_we}, 32'h2);
    c_txn(1'b0, 32'h10, 4'hF, 32'h0, lat, rd, err);
    check("byte_rd_data", rd, 32'hDEAD_5AEF);

    // Timer 0 PRESET write, timer 1 PRESET read.
    c_txn(1'b1, 32'h7F04, 4'hF, 32'h0000_1234, lat, rd, err);
    check("t0_wr_lat", lat, 32'd2);
    check("t0_wr_tm", {28'd0, acc_tm_we, acc_tm_addr}, 32'b0101);
    check("t0_wr_dm", {31'd0, |acc_dm_we}, 32'd0);
    c_txn(1'b0, 32'h7F14, 4'hF, 32'h0, lat, rd, err);
    check("t1_rd_data", rd, 32'h5);
    check("t1_rd_err", {31'd0, err}, 32'd0);
    check("t1_rd_tm", {28'd0, acc_tm_we, acc_tm_addr}, 32'b0001);

    // Illegal requests: error in one cycle, no strobes.
    bad_addr[0] = 32'h3000; bad_be[0] = 4'hF;    bad_we[0] = 1'b0;
    bad_addr[1] = 32'h0002; bad_be[1] = 4'hF;    bad_we[1] = 1'b0;
    bad_addr[2] = 32'h7F00; bad_be[2] = 4'b0011; bad_we[2] = 1'b0;
    bad_addr[3] = 32'h7F08; bad_be[3] = 4'hF;    bad_we[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_txn(bad_we[k], bad_addr[k], bad_be[k], 32'hFFFF_FFFF, lat, rd, err);
      check($sformatf("bad%0d_lat", k), lat, 32'd1);
      check($sformatf("bad%0d_err", k), {31'd0, err}, 32'd1);
      check($sformatf("bad%0d_strobe", k), {31'd0, strobe_seen}, 32'd0);
      check($sformatf("bad%0d_rdata", k), rd, 32'd0);
    end

    // Reset during ACCESS of a DM write; C was served last, so a stale
    // last_owner would hand the post-reset grant to D.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_be = 4'hF; c_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("rst_access_en", {31'd0, dm_en}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_drop_strobe", {27'd0, dm_en, dm_we}, 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; d_be = 4'hF;
    c_we = 1'b0; c_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_ack", {30'd0, c_ack, d_ack}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_grant_owner", {31'd0, owner}, 32'd0);
    acks = 0;
    for (int i = 0; i < 6 && acks == 0; i++) begin
      if (c_ack || d_ack) begin
        acks = 1;
        check("rst_first_ack", {30'd0, c_ack, d_ack}, 32'b10);
        check("rst_first_data", c_rdata, 32'hDEAD_5AEF);
        c_req = 1'b0; d_req = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    check("rst_ack_seen", acks, 32'd1);
    c_txn(1'b0, 32'h20, 4'hF, 32'h0, lat, rd, err);
    check("rst_dm_unwritten", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester data-bus controller between the CPU M-stage data port (port C) and the DMA/loader port (port D).
- Three slaves: data memory DM (0x0000_0000–0x0000_2FFF, synchronous read) and two timers T0 (0x7F00–0x7F0B) and T1 (0x7F10–0x7F1B), each with a combinational read.
- Arbitrates round-robin, checks each access for legality, sequences the slave strobes, and returns a one-cycle ack with read data or an error flag.

Parameters:
- DM_TOP, 32'h0000_2FFF, last valid DM byte address.
- T0_BASE, 32'h0000_7F00, timer 0 base; registers CTRL +0, PRESET +4, COUNT +8.
- T1_BASE, 32'h0000_7F10, timer 1 base; same register layout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state.
- c_req  in  1  port C request; held with its fields until c_ack.
- c_we  in  1  port C write (1) or read (0).
- c_addr  in  32  port C byte address.
- c_be  in  4  port C byte enables.
- c_wdata  in  32  port C write data, byte-lane aligned.
- c_ack  out  1  port C completion pulse.
- c_err  out  1  port C error, valid with c_ack.
- c_rdata  out  32  port C read word, valid with c_ack.
- d_req, d_we, d_addr, d_be, d_wdata, d_ack, d_err, d_rdata: same as port C, for port D.
- dm_en  out  1  DM access strobe.
- dm_we  out  4  DM byte write enables.
- dm_addr  out  12  DM word address, taken from addr[13:2].
- dm_wdata  out  32  DM write data.
- dm_rdata  in  32  DM read data, valid the cycle after dm_en.
- tm_we  out  2  timer write strobes; bit i selects timer i.
- tm_addr  out  2  timer register word offset.
- tm_wdata  out  32  timer write data.
- tm0_rdata  in  32  timer 0 read data, combinational.
- tm1_rdata  in  32  timer 1 read data, combinational.
- owner  out  1  port being served: 0 = C, 1 = D.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, last_owner = 1.
- Reset is asynchronous and may arrive mid-transaction. The transaction is dropped: no ack, no slave strobe, and it is not retried.
- The FSM has three states: IDLE, ACCESS and RESP.

IDLE:
- At each rising edge, sample c_req and d_req.
- If both are high, grant the port != last_owner. Otherwise grant the single requester.
- Latch the granted port's we, addr, be and wdata; set owner; set last_owner to the granted port.
- If the latched request is legal, go to ACCESS. If illegal, go to RESP with err = 1.
- If no request, stay in IDLE.

Legality (all must hold):
- Address is in DM range, T0 range or T1 range.
- be and addr[1:0] form one of these pairs:
  - 1111 with addr[1:0] = 00;
  - 0011 with addr[1:0] = 00;
  - 1100 with addr[1:0] = 10;
  - 0001 << addr[1:0], for any addr[1:0].
- A timer access must use be = 1111.
- A timer write must not target COUNT (offset +8).

ACCESS (exactly one cycle):
- Drive exactly one slave strobe from the latched registers.
  - DM: dm_en = 1, and dm_we = be if writing, else 0.
  - Timer: tm_we[i] = we for the selected timer, and tm_addr = addr[3:2].
- For a timer read, capture the rdata of the selected timer into the response register at the end of the cycle.
- Next state is RESP.

RESP (exactly one cycle):
- The owner's ack = 1. err reflects the legality check.
- rdata:
  - DM read: dm_rdata passed through this cycle.
  - Timer read: the captured value.
  - Write or error: 0.
- The non-owner's ack and err are 0. Next state is IDLE.

Latency:
- Measured from the IDLE edge that samples req.
- Legal access: ack is high in the 2nd cycle after that edge.
- Illegal access: ack is high in the 1st cycle after that edge.

Handshake and arbitration rules:
- Requester fields are ignored outside IDLE sampling.
- A requester must drop req in its ack cycle. A req still high at the next IDLE edge is treated as a new request.
- At most one transaction is in flight; the other port simply waits with its req held.
- Slave strobes never assert for an errored request, and never in IDLE or RESP.

Test Plan:
- Port C: write word 32'hDEAD_BEEF at 0x0000_0010 with be = 1111, then read it back. Response: dm_we = 1111 in ACCESS; the read returns c_rdata = 32'hDEAD_BEEF with c_ack two cycles after the sampling edge.
- Port C: write 0x7F04 with be = 1111. Response: tm_we = 01, tm_addr = 01. Then read 0x7F14 with tm1_rdata = 32'h5: c_rdata = 5, c_err = 0.
- Illegal requests, each driven separately:
  - 0x3000 (out of range);
  - 0x0002 with be = 1111 (misaligned);
  - 0x7F00 with be = 0011 (partial timer access);
  - write to 0x7F08 (COUNT).
  Each must give c_ack = 1 and c_err = 1 one cycle after sampling, with no dm_en or tm_we pulse.
- Arbitration: c_req and d_req held high together for 4 transactions. Grants must alternate C, D, C, D, starting with C after reset; owner must match each ack.
- Reset: assert reset (0) during ACCESS of a DM write. Response: dm_en and dm_we drop to 0 immediately, no ack occurs, and after reset is released with both reqs high, C is granted.
